// File: rtl/memory_bank_ctrl.sv
// memory_bank_ctrl: async bus slave that maps a banked, byte-laned ROM
// window onto a 16-bit data bus with DTACK_N handshake and wait states.
// Optional feature macro MEMORY_BANK_CTRL_BUS_ERROR_EN: misses and writes
// answer with BERR_N; when undefined they are silently ignored.
module memory_bank_ctrl #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned BASE_ADDR      = 12'h400,
  parameter int unsigned BANK_SIZE_LOG2 = 7,
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned WAIT_CYCLES    = 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        AS_N,
  input  logic                        RW,
  input  logic                        UDS_N,
  input  logic                        LDS_N,
  input  logic [ADDR_W-1:0]           ADDR,
  output logic [BANK_SIZE_LOG2-2:0]   ROM_ADDR,
  output logic [2*NUM_BANKS-1:0]      ROM_CS_N,
  input  logic [16*NUM_BANKS-1:0]     ROM_RDATA,
  output logic [15:0]                 DOUT,
  output logic                        DOE_HI,
  output logic                        DOE_LO,
  output logic                        DTACK_N,
  output logic                        BERR_N
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned WINDOW = NUM_BANKS << BANK_SIZE_LOG2;
  localparam int unsigned RA_W   = BANK_SIZE_LOG2 - 1;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT,
    ACK
`ifdef MEMORY_BANK_CTRL_BUS_ERROR_EN
    , ERR
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   armed_q, armed_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic                   uds_q, uds_d;
  logic                   lds_q, lds_d;
  logic [BANK_W-1:0]      bank_q, bank_d;
  logic [RA_W-1:0]        rom_addr_q, rom_addr_d;
  logic [2*NUM_BANKS-1:0] cs_q, cs_d;
  logic [15:0]            dout_q, dout_d;
  logic                   doe_hi_q, doe_hi_d;
  logic                   doe_lo_q, doe_lo_d;
  logic                   dtack_q, dtack_d;
`ifdef MEMORY_BANK_CTRL_BUS_ERROR_EN
  logic                   berr_q, berr_d;
`endif

  logic [31:0]       addr_ext;
  logic [31:0]       offset;
  logic              hit;
  logic [BANK_W-1:0] bank_sel;
  logic [15:0]       rd_word;

  // Window decode of the latched (even) address, done in wide arithmetic so
  // BASE_ADDR + window cannot wrap at ADDR_W bits.
  assign addr_ext = 32'(addr_q);
  assign offset   = addr_ext - BASE_ADDR;
  assign hit      = (addr_ext >= BASE_ADDR) && (addr_ext < BASE_ADDR + WINDOW);
  assign bank_sel = BANK_W'(offset >> BANK_SIZE_LOG2);
  assign rd_word  = ROM_RDATA[16*bank_q +: 16];

  // State register and all registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      uds_q      <= 1'b1;
      lds_q      <= 1'b1;
      bank_q     <= '0;
      rom_addr_q <= '0;
      cs_q       <= '1;
      dout_q     <= '0;
      doe_hi_q   <= 1'b0;
      doe_lo_q   <= 1'b0;
      dtack_q    <= 1'b1;
`ifdef MEMORY_BANK_CTRL_BUS_ERROR_EN
      berr_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      uds_q      <= uds_d;
      lds_q      <= lds_d;
      bank_q     <= bank_d;
      rom_addr_q <= rom_addr_d;
      cs_q       <= cs_d;
      dout_q     <= dout_d;
      doe_hi_q   <= doe_hi_d;
      doe_lo_q   <= doe_lo_d;
      dtack_q    <= dtack_d;
`ifdef MEMORY_BANK_CTRL_BUS_ERROR_EN
      berr_q     <= berr_d;
`endif
    end
  end

  // Next-state and next-output logic for the bus cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    // A new cycle may only start once AS_N has been seen high (after reset
    // or after any completed/aborted/ignored cycle).
    armed_d    = armed_q | AS_N;
    addr_d     = addr_q;
    rw_d       = rw_q;
    uds_d      = uds_q;
    lds_d      = lds_q;
    bank_d     = bank_q;
    rom_addr_d = rom_addr_q;
    cs_d       = cs_q;
    dout_d     = dout_q;
    doe_hi_d   = doe_hi_q;
    doe_lo_d   = doe_lo_q;
    dtack_d    = dtack_q;
`ifdef MEMORY_BANK_CTRL_BUS_ERROR_EN
    berr_d     = berr_q;
`endif
    case (state_q)
      IDLE: begin
        if (armed_q && !AS_N && (!UDS_N || !LDS_N)) begin
          addr_d  = ADDR & ~ADDR_W'(1);
          rw_d    = RW;
          uds_d   = UDS_N;
          lds_d   = LDS_N;
          armed_d = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (AS_N) begin
          state_d = IDLE;
        end else if (hit && rw_q) begin
          rom_addr_d = addr_q[BANK_SIZE_LOG2-1:1];
          bank_d     = bank_sel;
          cs_d       = '1;
          for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (BANK_W'(b) == bank_sel) begin
              cs_d[2*b]   = uds_q;
              cs_d[2*b+1] = lds_q;
            end
          end
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end else begin
`ifdef MEMORY_BANK_CTRL_BUS_ERROR_EN
          state_d = ERR;
`else
          state_d = IDLE;
`endif
        end
      end
      WAIT: begin
        if (AS_N) begin
          cs_d    = '1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          dout_d   = {uds_q ? 8'h00 : rd_word[15:8], lds_q ? 8'h00 : rd_word[7:0]};
          doe_hi_d = ~uds_q;
          doe_lo_d = ~lds_q;
          dtack_d  = 1'b0;
          state_d  = ACK;
        end
      end
      ACK: begin
        if (AS_N) begin
          cs_d     = '1;
          dout_d   = '0;
          doe_hi_d = 1'b0;
          doe_lo_d = 1'b0;
          dtack_d  = 1'b1;
          state_d  = IDLE;
        end
      end
`ifdef MEMORY_BANK_CTRL_BUS_ERROR_EN
      ERR: begin
        if (AS_N) begin
          berr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          berr_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign ROM_ADDR = rom_addr_q;
  assign ROM_CS_N = cs_q;
  assign DOUT     = dout_q;
  assign DOE_HI   = doe_hi_q;
  assign DOE_LO   = doe_lo_q;
  assign DTACK_N  = dtack_q;
`ifdef MEMORY_BANK_CTRL_BUS_ERROR_EN
  assign BERR_N   = berr_q;
`else
  assign BERR_N   = 1'b1;
`endif

endmodule

// File: tb/tb_memory_bank_ctrl.sv
// Bench for memory_bank_ctrl: two instances (default parameters, and a
// 4-bank / 256-byte-bank / zero-wait variant) share one bus. A transaction
// model pushes expected responses; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_memory_bank_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        AS_N;
  logic        RW;
  logic        UDS_N;
  logic        LDS_N;
  logic [11:0] ADDR;
  logic [63:0] rom_rd;

  logic [5:0]  a_ra;
  logic [3:0]  a_cs;
  logic [15:0] a_dout;
  logic        a_hi, a_lo, a_dt, a_be;
  logic [6:0]  b_ra;
  logic [7:0]  b_cs;
  logic [15:0] b_dout;
  logic        b_hi, b_lo, b_dt, b_be;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;
  logic        as_smp;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc    <= cyc + 1;
    as_smp <= AS_N;
  end

  memory_bank_ctrl u_a (
    .CLK(CLK), .RST_N(RST_N), .AS_N(AS_N), .RW(RW), .UDS_N(UDS_N), .LDS_N(LDS_N),
    .ADDR(ADDR), .ROM_ADDR(a_ra), .ROM_CS_N(a_cs), .ROM_RDATA(rom_rd[31:0]),
    .DOUT(a_dout), .DOE_HI(a_hi), .DOE_LO(a_lo), .DTACK_N(a_dt), .BERR_N(a_be)
  );

  memory_bank_ctrl #(
    .ADDR_W(12), .BASE_ADDR(12'h400), .BANK_SIZE_LOG2(8), .NUM_BANKS(4), .WAIT_CYCLES(0)
  ) u_b (
    .CLK(CLK), .RST_N(RST_N), .AS_N(AS_N), .RW(RW), .UDS_N(UDS_N), .LDS_N(LDS_N),
    .ADDR(ADDR), .ROM_ADDR(b_ra), .ROM_CS_N(b_cs), .ROM_RDATA(rom_rd),
    .DOUT(b_dout), .DOE_HI(b_hi), .DOE_LO(b_lo), .DTACK_N(b_dt), .BERR_N(b_be)
  );

  logic [7:0]  o_cs   [2];
  logic [7:0]  o_ra   [2];
  logic [15:0] o_dout [2];
  logic        o_hi   [2];
  logic        o_lo   [2];
  logic        o_dt   [2];
  logic        o_be   [2];

  assign o_cs[0] = {4'hF, a_cs};   assign o_cs[1] = b_cs;
  assign o_ra[0] = {2'b00, a_ra};  assign o_ra[1] = {1'b0, b_ra};
  assign o_dout[0] = a_dout;       assign o_dout[1] = b_dout;
  assign o_hi[0] = a_hi;           assign o_hi[1] = b_hi;
  assign o_lo[0] = a_lo;           assign o_lo[1] = b_lo;
  assign o_dt[0] = a_dt;           assign o_dt[1] = b_dt;
  assign o_be[0] = a_be;           assign o_be[1] = b_be;

  typedef struct {
    bit          err;
    int unsigned fall;
    int unsigned rise;
    logic [15:0] dout;
    logic        hi;
    logic        lo;
    logic [7:0]  cs;
    logic [7:0]  ra;
  } item_t;

  item_t       qa[$];
  item_t       qb[$];
  bit          prev_dt [2];
  bit          prev_be [2];
  bit          active  [2];
  int unsigned rise_exp[2];

  task automatic chk(input int i, input string nm, input bit ok,
                     input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s inst%0d @edge %0d: got %0h expected %0h", nm, i, cyc, got, exp);
    end
  endtask

  // Reference model: one bus transaction as seen by one instance.
  // n = number of edges AS_N is sampled low, starting at edge e0.
  task automatic predict(input int i, input logic [11:0] a, input bit rnw,
                         input bit uds, input bit lds, input int unsigned n,
                         input int unsigned e0, input logic [63:0] data);
    int unsigned bsl2, nb, w, win, ea, bank;
    logic [15:0] word;
    item_t it;
    bit hit;
    bsl2 = (i == 0) ? 7 : 8;
    nb   = (i == 0) ? 2 : 4;
    w    = (i == 0) ? 1 : 0;
    win  = nb << bsl2;
    ea   = 32'(a) & ~32'd1;
    if (uds && lds) return;
    hit = (ea >= 32'h400) && (ea < 32'h400 + win);
    if (rnw && hit) begin
      if (n < 3 + w) return;
      bank    = (ea - 32'h400) >> bsl2;
      word    = data[16*bank +: 16];
      it.err  = 1'b0;
      it.fall = e0 + 2 + w;
      it.rise = e0 + n;
      it.dout = {uds ? 8'h00 : word[15:8], lds ? 8'h00 : word[7:0]};
      it.hi   = ~uds;
      it.lo   = ~lds;
      it.cs   = 8'hFF;
      if (!uds) it.cs[2*bank]   = 1'b0;
      if (!lds) it.cs[2*bank+1] = 1'b0;
      it.ra   = 8'((ea >> 1) & ((32'd1 << (bsl2 - 1)) - 1));
      if (i == 0) qa.push_back(it); else qb.push_back(it);
    end else begin
`ifdef MEMORY_BANK_CTRL_BUS_ERROR_EN
      if (n >= 3) begin
        it.err  = 1'b1;
        it.fall = e0 + 2;
        it.rise = e0 + n;
        it.dout = '0;
        it.hi   = 1'b0;
        it.lo   = 1'b0;
        it.cs   = 8'hFF;
        it.ra   = '0;
        if (i == 0) qa.push_back(it); else qb.push_back(it);
      end
`endif
    end
  endtask

  task automatic mon(input int i);
    item_t it;
    bit got, fell_dt, fell_be, rose;
    if (!RST_N) begin
      if (i == 0) qa.delete(); else qb.delete();
      active[i]  = 1'b0;
      prev_dt[i] = 1'b1;
      prev_be[i] = 1'b1;
      return;
    end
    chk(i, "dtack_berr_exclusive", !(o_dt[i] == 1'b0 && o_be[i] == 1'b0),
        {o_dt[i], o_be[i]}, 2'b11);
    if (as_smp === 1'b1)
      chk(i, "idle_outputs", (o_cs[i] == 8'hFF) && o_dt[i] && o_be[i] && !o_hi[i] && !o_lo[i],
          {o_cs[i], o_dt[i], o_be[i], o_hi[i], o_lo[i]}, {8'hFF, 4'b1100});
    fell_dt = prev_dt[i] && !o_dt[i];
    fell_be = prev_be[i] && !o_be[i];
    if (fell_dt || fell_be) begin
      got = 1'b0;
      if (i == 0 && qa.size() > 0) begin it = qa.pop_front(); got = 1'b1; end
      else if (i == 1 && qb.size() > 0) begin it = qb.pop_front(); got = 1'b1; end
      chk(i, "response_expected", got, 1, 0);
      if (got) begin
        chk(i, "response_kind_berr", fell_be == it.err, fell_be, it.err);
        chk(i, "response_edge", cyc == it.fall, cyc, it.fall);
        if (!it.err) begin
          chk(i, "dout", o_dout[i] == it.dout, o_dout[i], it.dout);
          chk(i, "doe_hi_lo", {o_hi[i], o_lo[i]} == {it.hi, it.lo},
              {o_hi[i], o_lo[i]}, {it.hi, it.lo});
          chk(i, "rom_cs_n", o_cs[i] == it.cs, o_cs[i], it.cs);
          chk(i, "rom_addr", o_ra[i] == it.ra, o_ra[i], it.ra);
        end
        active[i]   = 1'b1;
        rise_exp[i] = it.rise;
      end
    end
    rose = (!prev_dt[i] && o_dt[i]) || (!prev_be[i] && o_be[i]);
    if (rose) begin
      chk(i, "response_release_edge", active[i] && (cyc == rise_exp[i]), cyc, rise_exp[i]);
      active[i] = 1'b0;
    end
    prev_dt[i] = o_dt[i];
    prev_be[i] = o_be[i];
  endtask

  // Monitor: compares DUT responses against queued expectations.
  always @(negedge CLK) begin
    mon(0);
    mon(1);
  end

  task automatic xfer(input logic [11:0] a, input bit rnw, input bit uds, input bit lds,
                      input int unsigned n, input int unsigned gap, input logic [63:0] data);
    int unsigned e0;
    @(posedge CLK); #1;
    e0     = cyc + 1;
    ADDR   = a;
    RW     = rnw;
    UDS_N  = uds;
    LDS_N  = lds;
    rom_rd = data;
    AS_N   = 1'b0;
    predict(0, a, rnw, uds, lds, n, e0, data);
    predict(1, a, rnw, uds, lds, n, e0, data);
    @(posedge CLK); #1;
    // Once latched, bus changes must not affect the cycle.
    if (!(uds && lds)) begin
      ADDR  = 12'($urandom);
      RW    = 1'($urandom);
      UDS_N = 1'($urandom);
      LDS_N = 1'($urandom);
    end
    repeat (n - 1) @(posedge CLK);
    #1;
    AS_N = 1'b1;
    repeat (gap - 1) @(posedge CLK);
  endtask

  initial begin
    int unsigned e0;
    logic [11:0] a;
    logic [1:0]  st;
    RST_N  = 1'b0;
    AS_N   = 1'b1;
    RW     = 1'b1;
    UDS_N  = 1'b1;
    LDS_N  = 1'b1;
    ADDR   = '0;
    rom_rd = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk(0, "reset_outputs", {a_cs, a_ra, a_dout, a_hi, a_lo, a_dt, a_be} == {4'hF, 6'd0, 16'h0, 4'b0011},
        {a_cs, a_ra, a_dout, a_hi, a_lo, a_dt, a_be}, {4'hF, 6'd0, 16'h0, 4'b0011});
    chk(1, "reset_outputs", {b_cs, b_ra, b_dout, b_hi, b_lo, b_dt, b_be} == {8'hFF, 7'd0, 16'h0, 4'b0011},
        {b_cs, b_ra, b_dout, b_hi, b_lo, b_dt, b_be}, {8'hFF, 7'd0, 16'h0, 4'b0011});
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    xfer(12'h402, 1'b1, 1'b0, 1'b0, 6, 2, 64'h0000_0000_0000_A55A);
    xfer(12'h4C4, 1'b1, 1'b1, 1'b0, 6, 2, 64'h0000_0000_1234_BEEF);
    xfer(12'h500, 1'b1, 1'b0, 1'b0, 6, 2, 64'h1111_2222_3333_4444);
    xfer(12'h402, 1'b1, 1'b0, 1'b0, 3, 1, 64'h0000_0000_0000_9876);
    xfer(12'h7FE, 1'b1, 1'b0, 1'b0, 5, 1, 64'hC0DE_7777_6666_5555);
    xfer(12'h402, 1'b0, 1'b0, 1'b0, 5, 1, 64'h0000_0000_0000_5A5A);
    xfer(12'h4FF, 1'b1, 1'b0, 1'b1, 4, 1, 64'h0000_0000_ABCD_0000);

    // Reset pulse while both instances sit in the acknowledge phase.
    @(posedge CLK); #1;
    e0     = cyc + 1;
    ADDR   = 12'h402;
    RW     = 1'b1;
    UDS_N  = 1'b0;
    LDS_N  = 1'b0;
    rom_rd = 64'h0000_0000_0000_C3C3;
    AS_N   = 1'b0;
    predict(0, ADDR, 1'b1, 1'b0, 1'b0, 1000, e0, rom_rd);
    predict(1, ADDR, 1'b1, 1'b0, 1'b0, 1000, e0, rom_rd);
    repeat (5) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk(0, "reset_in_ack", {a_dt, a_hi, a_lo} == 3'b100, {a_dt, a_hi, a_lo}, 3'b100);
    chk(1, "reset_in_ack", {b_dt, b_hi, b_lo} == 3'b100, {b_dt, b_hi, b_lo}, 3'b100);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk(0, "no_cycle_after_reset", a_cs == 4'hF, a_cs, 4'hF);
    chk(1, "no_cycle_after_reset", b_cs == 8'hFF, b_cs, 8'hFF);
    AS_N = 1'b1;
    @(posedge CLK);
    xfer(12'h404, 1'b1, 1'b0, 1'b0, 5, 2, 64'h0000_0000_0000_0F0F);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 3))
        0: a = 12'(12'h400 + $urandom_range(0, 255));
        1: a = 12'(12'h400 + $urandom_range(0, 1023));
        2: a = 12'($urandom);
        default: begin
          case ($urandom_range(0, 7))
            0: a = 12'h3FE;
            1: a = 12'h400;
            2: a = 12'h4FE;
            3: a = 12'h500;
            4: a = 12'h7FE;
            5: a = 12'h800;
            6: a = 12'h401;
            default: a = 12'hFFE;
          endcase
        end
      endcase
      st = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      xfer(a, ($urandom_range(0, 4) != 0), st[1], st[0],
           $urandom_range(1, 7), $urandom_range(1, 3), {$urandom, $urandom});
    end

    repeat (4) @(posedge CLK);
    #1;
    chk(0, "pending_expectations", (qa.size() == 0) && !active[0], qa.size(), 0);
    chk(1, "pending_expectations", (qb.size() == 0) && !active[1], qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_bank_ctrl.md
MEMORY_BANK_CTRL -- requirements
Module: memory_bank_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 12'h400, first byte address of the ROM window.
REQ-003 SHALL have parameter BANK_SIZE_LOG2, default 7, log2 of bytes per bank (hi+lo lanes combined).
REQ-004 SHALL have parameter NUM_BANKS, default 2, number of banks; window = NUM_BANKS<<BANK_SIZE_LOG2 bytes.
REQ-005 SHALL have parameter WAIT_CYCLES, default 1, ROM access wait states (0..15).
REQ-006 SHALL have ports, in order:
- CLK  in  1  single clock, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- AS_N  in  1  bus address strobe, active low.
- RW  in  1  1 = read, 0 = write.
- UDS_N, LDS_N  in  1 each  upper (D[15:8]) and lower (D[7:0]) byte strobes, active low.
- ADDR  in  ADDR_W  byte address; bit 0 ignored.
- ROM_ADDR  out  BANK_SIZE_LOG2-1  word address to all ROMs.
- ROM_CS_N  out  2*NUM_BANKS  chip selects; bit 2b = bank b upper lane, bit 2b+1 = bank b lower lane.
- ROM_RDATA  in  16*NUM_BANKS  bank b data at [16b+15:16b], upper byte = upper lane.
- DOUT  out  16  read data.
- DOE_HI, DOE_LO  out  1 each  byte-lane output enables.
- DTACK_N  out  1  transfer acknowledge.
- BERR_N  out  1  bus error (BUS_ERROR_EN only; tied high otherwise).

Function
REQ-007 SHALL implement FSM states IDLE, DECODE, WAIT, ACK, ERR.
REQ-008 IDLE: on an edge with AS_N=0 and (UDS_N=0 or LDS_N=0), SHALL latch ADDR, RW, UDS_N, LDS_N and go to DECODE.
REQ-009 DECODE: hit = BASE_ADDR <= addr < BASE_ADDR+window; bank = (addr-BASE_ADDR)>>BANK_SIZE_LOG2, width ceil(log2(NUM_BANKS)) min 1.
REQ-010 DECODE, hit and read: SHALL register ROM_ADDR = addr[BANK_SIZE_LOG2-1:1], assert ROM_CS_N low only for the selected bank lanes whose strobes are low, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-011 DECODE, miss or write: SHALL go to ERR with BUS_ERROR_EN; without it, SHALL return to IDLE with no acknowledge.
REQ-012 WAIT: counter nonzero -> decrement; counter zero -> capture the selected bank's ROM_RDATA into the DOUT register and go to ACK.
REQ-013 Latency: with AS_N sampled low at edge 0, DTACK_N SHALL go low after edge 2+WAIT_CYCLES.
REQ-014 ACK: DTACK_N=0; DOE_HI/DOE_LO SHALL be 1 only for the requested lanes; disabled lanes of DOUT read 8'h00.
REQ-015 ACK/ERR: SHALL hold until AS_N sampled high, then deassert all outputs and return to IDLE on that edge.
REQ-016 AS_N high during DECODE or WAIT SHALL abort: next state IDLE, all CS deasserted, no DTACK_N or BERR_N pulse.
REQ-017 Strobe or address changes after latch SHALL be ignored until the next IDLE.
REQ-018 Back-to-back accesses need AS_N high for at least one sampled edge; AS_N held low after ACK SHALL not start a new cycle.
REQ-019 All outputs SHALL be registered; DTACK_N and BERR_N SHALL never be low simultaneously.

Reset
REQ-020 RST_N low SHALL immediately force: state IDLE, counter 0, ROM_CS_N all 1, ROM_ADDR 0, DOUT 16'h0000, DOE_HI/DOE_LO 0, DTACK_N 1, BERR_N 1.
REQ-021 Reset asserted mid-cycle SHALL abandon the access; after release the block SHALL wait for a fresh AS_N assertion from IDLE.

Configuration
REQ-022 Macro MEMORY_BANK_CTRL_BUS_ERROR_EN defined: ERR state present; misses and writes drive BERR_N low per REQ-011/REQ-015.
REQ-023 Macro undefined: ERR state and its logic SHALL be omitted; BERR_N constant 1; misses and writes SHALL be ignored (bus timeout handled externally).

Verification
REQ-024 Defaults; read ADDR=12'h402, UDS_N=LDS_N=0, bank0 data 16'hA55A, WAIT_CYCLES=1 -> ROM_CS_N=4'b1100, ROM_ADDR=6'd1, DTACK_N low after edge 3, DOUT=16'hA55A, both DOEs set.
REQ-025 Read ADDR=12'h4C4, LDS_N=0 only, bank1 data 16'h1234 -> ROM_CS_N=4'b0111, DOUT=16'h0034, DOE_LO=1, DOE_HI=0.
REQ-026 Read ADDR=12'h500 with BUS_ERROR_EN -> BERR_N low after edge 2 until AS_N high, DTACK_N stays 1. Without the macro -> no response, FSM in IDLE.
REQ-027 AS_N raised during WAIT with WAIT_CYCLES=3 -> ROM_CS_N all 1 on the next edge, DTACK_N never low.
REQ-028 RST_N pulsed low during ACK -> DTACK_N=1 and DOE_*=0 immediately; AS_N still low after release -> no new cycle until AS_N toggles.
REQ-029 NUM_BANKS=4, BANK_SIZE_LOG2=8, WAIT_CYCLES=0, read ADDR=12'h7FE -> bank 3 selected, DTACK_N low after edge 2.
